// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the Zicsr access sequencer: funct3 codes,
// FSM state encoding, read-only address field and the operation decode.
package csr_access_ctrl_pkg;

    // Zicsr funct3 encodings (the INST_CSRR* set)
    localparam logic [2:0] INST_CSRRW  = 3'b001;
    localparam logic [2:0] INST_CSRRS  = 3'b010;
    localparam logic [2:0] INST_CSRRC  = 3'b011;
    localparam logic [2:0] INST_CSRRWI = 3'b101;
    localparam logic [2:0] INST_CSRRSI = 3'b110;
    localparam logic [2:0] INST_CSRRCI = 3'b111;

    // csr_addr[11:10] value that marks a read-only CSR
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } csr_state_e;

    // Operation class shared by the register and immediate forms
    typedef enum logic [1:0] {
        OP_RW   = 2'd0,
        OP_RS   = 2'd1,
        OP_RC   = 2'd2,
        OP_NONE = 2'd3
    } csr_op_e;

    // funct3[2] only selects the operand source, funct3[1:0] the operation
    function automatic csr_op_e decode_op(input logic [2:0] funct3);
        csr_op_e op;
        case (funct3[1:0])
            2'b01:   op = OP_RW;
            2'b10:   op = OP_RS;
            2'b11:   op = OP_RC;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request, CSR-file and GPR write-back signals of the CSR access sequencer.
// The slave modport is the sequencer's view; master is the surrounding
// pipeline / CSR file view.
interface csr_access_ctrl_if #(
    parameter int MXLEN = 32
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic [2:0]       i_funct3;
    logic [11:0]      i_csr_addr;
    logic [4:0]       i_rs1_addr_uimm;
    logic [4:0]       i_rd_addr;
    logic [MXLEN-1:0] i_rs1_data;
    logic [1:0]       i_priv;
    logic [11:0]      o_csr_addr;
    logic             o_csr_rd_en;
    logic             i_csr_rd_valid;
    logic [MXLEN-1:0] i_csr_rd_data;
    logic             o_csr_wr_en;
    logic [MXLEN-1:0] o_csr_wr_data;
    logic             o_rd_we;
    logic [4:0]       o_rd_addr;
    logic [MXLEN-1:0] o_rd_data;
    logic             o_done;
    logic             o_illegal;

    modport slave (
        input  i_req_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr,
               i_rs1_data, i_priv, i_csr_rd_valid, i_csr_rd_data,
        output o_req_ready, o_csr_addr, o_csr_rd_en, o_csr_wr_en, o_csr_wr_data,
               o_rd_we, o_rd_addr, o_rd_data, o_done, o_illegal
    );

    modport master (
        output i_req_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr,
               i_rs1_data, i_priv, i_csr_rd_valid, i_csr_rd_data,
        input  o_req_ready, o_csr_addr, o_csr_rd_en, o_csr_wr_en, o_csr_wr_data,
               o_rd_we, o_rd_addr, o_rd_data, o_done, o_illegal
    );
endinterface

// File: rtl/csr_access_ctrl_alu.sv
// Combinational CSR modify unit: (op, old, operand) -> new CSR value.
module csr_access_ctrl_alu
    import csr_access_ctrl_pkg::*;
#(
    parameter int MXLEN = 32
) (
    input  csr_op_e          op,
    input  logic [MXLEN-1:0] old_val,
    input  logic [MXLEN-1:0] operand,
    output logic [MXLEN-1:0] new_val
);

    // Select write / set-bits / clear-bits of the old value
    always_comb begin
        new_val = {MXLEN{1'b0}};
        case (op)
            OP_RW:   new_val = operand;
            OP_RS:   new_val = old_val | operand;
            OP_RC:   new_val = old_val & ~operand;
            default: new_val = {MXLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Zicsr initiator-side sequencer: accepts one decoded CSR instruction,
// performs the read / modify / write against the CSR file and returns the
// old value to the GPR write port, flagging illegal accesses.
// Optional build macro: CSR_PRIV_CHECK_EN adds privilege and read-only
// write checks at accept time.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int MXLEN      = 32,
    parameter int RD_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    csr_access_ctrl_if.slave bus
);

    localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // FSM and latched request
    csr_state_e       state_r;
    csr_op_e          op_r;
    logic [MXLEN-1:0] operand_r;
    logic [4:0]       rd_idx_r;
    logic             do_write_r;
    logic [CNT_W-1:0] cnt_r;

    // Registered outputs
    logic             ready_r;
    logic [11:0]      csr_addr_r;
    logic             rd_en_r;
    logic             wr_en_r;
    logic [MXLEN-1:0] wr_data_r;
    logic             rd_we_r;
    logic [4:0]       rd_addr_out_r;
    logic [MXLEN-1:0] rd_data_r;
    logic             done_r;
    logic             illegal_r;

    // Request decode (valid only while in IDLE)
    csr_op_e          req_op_s;
    logic [MXLEN-1:0] req_operand_s;
    logic             req_do_read_s;
    logic             req_do_write_s;
    logic             req_priv_fault_s;
    logic             req_illegal_s;

    // ALU operand selection
    csr_op_e          alu_op_s;
    logic [MXLEN-1:0] alu_operand_s;
    logic [MXLEN-1:0] alu_old_s;
    logic [MXLEN-1:0] alu_new_s;

    // Decode the incoming instruction into operation, operand and access needs
    always_comb begin
        req_op_s = decode_op(bus.i_funct3);
        if (bus.i_funct3[2]) begin
            req_operand_s = {{(MXLEN-5){1'b0}}, bus.i_rs1_addr_uimm};
        end else begin
            req_operand_s = bus.i_rs1_data;
        end
        if (req_op_s == OP_RW) begin
            req_do_read_s  = (bus.i_rd_addr != 5'd0);
            req_do_write_s = 1'b1;
        end else begin
            req_do_read_s  = 1'b1;
            req_do_write_s = (bus.i_rs1_addr_uimm != 5'd0);
        end
    end

`ifdef CSR_PRIV_CHECK_EN
    // Privilege-level and read-only-write checks on the incoming request
    always_comb begin
        if ((bus.i_priv < bus.i_csr_addr[9:8]) ||
            ((bus.i_csr_addr[11:10] == CSR_RO_FIELD) && req_do_write_s)) begin
            req_priv_fault_s = 1'b1;
        end else begin
            req_priv_fault_s = 1'b0;
        end
    end
`else
    // Without the check, privilege is ignored and read-only writes go to the CSR file
    logic unused_priv_s;
    assign unused_priv_s    = ^bus.i_priv;
    assign req_priv_fault_s = 1'b0;
`endif

    assign req_illegal_s = (req_op_s == OP_NONE) || req_priv_fault_s;

    // Feed the ALU from the live request in IDLE, else from the latched one
    always_comb begin
        if (state_r == ST_IDLE) begin
            alu_op_s      = req_op_s;
            alu_operand_s = req_operand_s;
        end else begin
            alu_op_s      = op_r;
            alu_operand_s = operand_r;
        end
        if (state_r == ST_WAIT) begin
            alu_old_s = bus.i_csr_rd_data;
        end else begin
            alu_old_s = {MXLEN{1'b0}};
        end
    end

    csr_access_ctrl_alu #(
        .MXLEN(MXLEN)
    ) u_alu (
        .op      (alu_op_s),
        .old_val (alu_old_s),
        .operand (alu_operand_s),
        .new_val (alu_new_s)
    );

    // Sequencer FSM with registered strobes and data outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_NONE;
            operand_r     <= {MXLEN{1'b0}};
            rd_idx_r      <= 5'd0;
            do_write_r    <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            ready_r       <= 1'b1;
            csr_addr_r    <= 12'd0;
            rd_en_r       <= 1'b0;
            wr_en_r       <= 1'b0;
            wr_data_r     <= {MXLEN{1'b0}};
            rd_we_r       <= 1'b0;
            rd_addr_out_r <= 5'd0;
            rd_data_r     <= {MXLEN{1'b0}};
            done_r        <= 1'b0;
            illegal_r     <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
            rd_we_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_req_valid) begin
                        ready_r       <= 1'b0;
                        csr_addr_r    <= bus.i_csr_addr;
                        op_r          <= req_op_s;
                        operand_r     <= req_operand_s;
                        rd_idx_r      <= bus.i_rd_addr;
                        do_write_r    <= req_do_write_s;
                        rd_addr_out_r <= bus.i_rd_addr;
                        if (req_illegal_s) begin
                            state_r   <= ST_COMMIT;
                            done_r    <= 1'b1;
                            illegal_r <= 1'b1;
                        end else if (req_do_read_s) begin
                            state_r <= ST_READ;
                            rd_en_r <= 1'b1;
                        end else begin
                            // write-only: RW/RWI to x0, old value never needed
                            state_r   <= ST_COMMIT;
                            done_r    <= 1'b1;
                            illegal_r <= 1'b0;
                            wr_en_r   <= req_do_write_s;
                            wr_data_r <= alu_new_s;
                            rd_data_r <= {MXLEN{1'b0}};
                        end
                    end
                end
                ST_READ: begin
                    state_r <= ST_WAIT;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                ST_WAIT: begin
                    if (bus.i_csr_rd_valid) begin
                        state_r   <= ST_COMMIT;
                        done_r    <= 1'b1;
                        illegal_r <= 1'b0;
                        wr_en_r   <= do_write_r;
                        wr_data_r <= alu_new_s;
                        rd_we_r   <= (rd_idx_r != 5'd0);
                        rd_data_r <= bus.i_csr_rd_data;
                    end else if (cnt_r == CNT_LAST) begin
                        // read abandoned: report illegal, never retried
                        state_r   <= ST_COMMIT;
                        done_r    <= 1'b1;
                        illegal_r <= 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_COMMIT: begin
                    state_r       <= ST_IDLE;
                    ready_r       <= 1'b1;
                    csr_addr_r    <= 12'd0;
                    illegal_r     <= 1'b0;
                    wr_data_r     <= {MXLEN{1'b0}};
                    rd_data_r     <= {MXLEN{1'b0}};
                    rd_addr_out_r <= 5'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_req_ready   = ready_r;
    assign bus.o_csr_addr    = csr_addr_r;
    assign bus.o_csr_rd_en   = rd_en_r;
    assign bus.o_csr_wr_en   = wr_en_r;
    assign bus.o_csr_wr_data = wr_data_r;
    assign bus.o_rd_we       = rd_we_r;
    assign bus.o_rd_addr     = rd_addr_out_r;
    assign bus.o_rd_data     = rd_data_r;
    assign bus.o_done        = done_r;
    assign bus.o_illegal     = illegal_r;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus
// randomized instructions checked against a behavioural outcome model.
module tb_csr_access_ctrl;

    localparam int TO = 15;

    logic clk;
    logic rst;
    int   compared;
    int   errors;

    csr_access_ctrl_if #(.MXLEN(32)) bus();

    csr_access_ctrl #(
        .MXLEN      (32),
        .RD_TIMEOUT (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          done_k;
        int          rden_k;
        int          rden_cnt;
        int          stray;
        int          addr_bad;
        logic        ready0;
        logic        illegal;
        logic        wr_en;
        logic        rd_we;
        logic [31:0] wr_data;
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
    } obs_t;

    function automatic obs_t blank();
        obs_t o;
        o.done_k = 0; o.rden_k = 0; o.rden_cnt = 0; o.stray = 0; o.addr_bad = 0;
        o.ready0 = 1'b0; o.illegal = 1'b0; o.wr_en = 1'b0; o.rd_we = 1'b0;
        o.wr_data = 32'd0; o.rd_data = 32'd0; o.rd_addr = 5'd0;
        return o;
    endfunction

    // Expected outcome of one instruction, from the instruction-level rules
    function automatic obs_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [4:0] uimm, input logic [4:0] rd,
                                   input logic [31:0] rs1, input logic [1:0] priv,
                                   input logic [31:0] old, input int lat);
        obs_t e;
        logic [1:0]  kind;
        logic [31:0] opnd;
        bit          needs_read;
        bit          needs_write;
        bit          legal;
        e = blank();
        e.ready0 = 1'b1;
        kind = f3[1:0];
        opnd = f3[2] ? {27'd0, uimm} : rs1;
        needs_read  = (kind == 2'd1) ? (rd != 5'd0) : 1'b1;
        needs_write = (kind == 2'd1) ? 1'b1 : (uimm != 5'd0);
        legal = (kind != 2'd0);
`ifdef CSR_PRIV_CHECK_EN
        if ((priv < addr[9:8]) || ((addr[11:10] == 2'b11) && needs_write)) legal = 1'b0;
`else
        if ((priv == 2'd2) && (addr == 12'hFFF)) legal = legal;
`endif
        if (!legal) begin
            e.done_k = 1; e.illegal = 1'b1;
        end else if (!needs_read) begin
            e.done_k = 1; e.wr_en = needs_write; e.wr_data = opnd;
        end else begin
            e.rden_k = 1; e.rden_cnt = 1;
            if (lat > TO) begin
                e.done_k = 2 + TO; e.illegal = 1'b1;
            end else begin
                e.done_k  = 2 + lat;
                e.wr_en   = needs_write;
                e.wr_data = (kind == 2'd1) ? opnd : (kind == 2'd2) ? (old | opnd) : (old & ~opnd);
                e.rd_we   = (rd != 5'd0);
                e.rd_data = old;
                e.rd_addr = rd;
            end
        end
        return e;
    endfunction

    // Drive one instruction, act as CSR file (answer after lat WAIT cycles), observe
    task automatic run_instr(input logic [2:0] f3, input logic [11:0] addr,
                             input logic [4:0] uimm, input logic [4:0] rd,
                             input logic [31:0] rs1, input logic [1:0] priv,
                             input logic [31:0] old, input int lat, output obs_t o);
        o = blank();
        @(negedge clk);
        o.ready0 = bus.o_req_ready;
        if (bus.o_csr_addr !== 12'd0) o.addr_bad++;
        bus.i_req_valid = 1'b1; bus.i_funct3 = f3; bus.i_csr_addr = addr;
        bus.i_rs1_addr_uimm = uimm; bus.i_rd_addr = rd; bus.i_rs1_data = rs1; bus.i_priv = priv;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_req_valid = 1'b0; bus.i_funct3 = 3'($urandom); bus.i_csr_addr = 12'($urandom);
                bus.i_rs1_addr_uimm = 5'($urandom); bus.i_rd_addr = 5'($urandom);
                bus.i_rs1_data = $urandom; bus.i_priv = 2'($urandom);
            end
            if (bus.o_csr_addr !== addr) o.addr_bad++;
            if (bus.o_csr_rd_en === 1'b1) begin
                if (o.rden_cnt == 0) o.rden_k = k;
                o.rden_cnt++;
            end
            if (bus.o_done === 1'b1) begin
                o.done_k = k; o.illegal = bus.o_illegal; o.wr_en = bus.o_csr_wr_en;
                o.rd_we = bus.o_rd_we; o.wr_data = bus.o_csr_wr_data;
                o.rd_data = bus.o_rd_data; o.rd_addr = bus.o_rd_addr;
                break;
            end
            if (bus.o_csr_wr_en !== 1'b0 || bus.o_rd_we !== 1'b0 || bus.o_illegal !== 1'b0) o.stray++;
            bus.i_csr_rd_valid = (k == 1 + lat);
            bus.i_csr_rd_data  = (k == 1 + lat) ? old : $urandom;
        end
        bus.i_csr_rd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.i_req_valid = 1'b0; bus.i_funct3 = 3'd0; bus.i_csr_addr = 12'd0;
        bus.i_rs1_addr_uimm = 5'd0; bus.i_rd_addr = 5'd0; bus.i_rs1_data = 32'd0;
        bus.i_priv = 2'd3; bus.i_csr_rd_valid = 1'b0; bus.i_csr_rd_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        compared++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.o_req_ready); end
        compared++;
        if ({bus.o_csr_rd_en, bus.o_csr_wr_en, bus.o_rd_we, bus.o_done, bus.o_illegal} !== 5'd0 ||
            bus.o_csr_addr !== 12'd0 || bus.o_csr_wr_data !== 32'd0 || bus.o_rd_data !== 32'd0 || bus.o_rd_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got rd_en=%b wr_en=%b rd_we=%b done=%b ill=%b addr=%h wd=%h rdd=%h ra=%0d exp all 0",
                     bus.o_csr_rd_en, bus.o_csr_wr_en, bus.o_rd_we, bus.o_done, bus.o_illegal,
                     bus.o_csr_addr, bus.o_csr_wr_data, bus.o_rd_data, bus.o_rd_addr);
        end
    endtask

    task automatic test_rw();
        obs_t o;
        run_instr(3'b001, 12'h340, 5'd7, 5'd5, 32'hDEADBEEF, 2'd3, 32'h12, 1, o);
        compared++; if (o.rden_k !== 1 || o.rden_cnt !== 1) begin errors++; $display("FAIL rw_rd_en got k=%0d n=%0d exp k=1 n=1", o.rden_k, o.rden_cnt); end
        compared++; if (o.done_k !== 3) begin errors++; $display("FAIL rw_commit_cycle got %0d exp 3", o.done_k); end
        compared++; if (o.wr_en !== 1'b1 || o.wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_write got en=%b d=%h exp en=1 d=deadbeef", o.wr_en, o.wr_data); end
        compared++; if (o.rd_we !== 1'b1 || o.rd_data !== 32'h12 || o.rd_addr !== 5'd5) begin errors++; $display("FAIL rw_gpr got we=%b d=%h a=%0d exp we=1 d=12 a=5", o.rd_we, o.rd_data, o.rd_addr); end
        compared++; if (o.addr_bad !== 0 || o.stray !== 0) begin errors++; $display("FAIL rw_protocol got addr_bad=%0d stray=%0d exp 0 0", o.addr_bad, o.stray); end
        run_instr(3'b001, 12'h340, 5'd3, 5'd0, 32'h55, 2'd3, 32'h99, 1, o);
        compared++; if (o.done_k !== 1 || o.rden_cnt !== 0) begin errors++; $display("FAIL rw_x0_timing got done=%0d rden=%0d exp 1 0", o.done_k, o.rden_cnt); end
        compared++; if (o.wr_en !== 1'b1 || o.wr_data !== 32'h55 || o.rd_we !== 1'b0) begin errors++; $display("FAIL rw_x0_strobes got wr=%b d=%h we=%b exp 1 55 0", o.wr_en, o.wr_data, o.rd_we); end
    endtask

    task automatic test_set_clear();
        obs_t o;
        run_instr(3'b010, 12'h300, 5'd0, 5'd7, 32'hFFFF_FFFF, 2'd3, 32'h1888, 2, o);
        compared++; if (o.done_k !== 4 || o.wr_en !== 1'b0) begin errors++; $display("FAIL rs_x0_read_only got done=%0d wr=%b exp 4 0", o.done_k, o.wr_en); end
        compared++; if (o.rd_we !== 1'b1 || o.rd_data !== 32'h1888) begin errors++; $display("FAIL rs_x0_gpr got we=%b d=%h exp 1 1888", o.rd_we, o.rd_data); end
        run_instr(3'b111, 12'h344, 5'd3, 5'd9, 32'hFFFF_FFFF, 2'd3, 32'hF, 1, o);
        compared++; if (o.wr_en !== 1'b1 || o.wr_data !== 32'hC || o.rd_data !== 32'hF) begin errors++; $display("FAIL rci_value got wr=%b d=%h old=%h exp 1 c f", o.wr_en, o.wr_data, o.rd_data); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_instr(3'b010, 12'h341, 5'd4, 5'd6, 32'h1, 2'd3, 32'h77, TO + 10, o);
        compared++; if (o.done_k !== 2 + TO || o.illegal !== 1'b1) begin errors++; $display("FAIL timeout_commit got done=%0d ill=%b exp %0d 1", o.done_k, o.illegal, 2 + TO); end
        compared++; if (o.wr_en !== 1'b0 || o.rd_we !== 1'b0 || o.rden_cnt !== 1) begin errors++; $display("FAIL timeout_strobes got wr=%b we=%b rden=%0d exp 0 0 1", o.wr_en, o.rd_we, o.rden_cnt); end
        // late read data arrives while idle
        @(negedge clk);
        bus.i_csr_rd_valid = 1'b1; bus.i_csr_rd_data = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.i_csr_rd_valid = 1'b0;
        compared++; if (bus.o_done !== 1'b0 || bus.o_rd_we !== 1'b0 || bus.o_csr_wr_en !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            errors++; $display("FAIL spurious_valid got done=%b we=%b wr=%b rdy=%b exp 0 0 0 1", bus.o_done, bus.o_rd_we, bus.o_csr_wr_en, bus.o_req_ready); end
        run_instr(3'b011, 12'h342, 5'd0, 5'd8, 32'h0, 2'd3, 32'h1234, 2, o);
        compared++; if (o.done_k !== 4 || o.rd_data !== 32'h1234 || o.illegal !== 1'b0) begin errors++; $display("FAIL after_spurious got done=%0d d=%h ill=%b exp 4 1234 0", o.done_k, o.rd_data, o.illegal); end
    endtask

    task automatic test_illegal();
        obs_t o;
        run_instr(3'b100, 12'h340, 5'd2, 5'd5, 32'h1, 2'd3, 32'h5, 1, o);
        compared++; if (o.done_k !== 1 || o.illegal !== 1'b1 || o.wr_en !== 1'b0 || o.rd_we !== 1'b0 || o.rden_cnt !== 0) begin
            errors++; $display("FAIL funct3_100 got done=%0d ill=%b wr=%b we=%b rden=%0d exp 1 1 0 0 0", o.done_k, o.illegal, o.wr_en, o.rd_we, o.rden_cnt); end
        run_instr(3'b000, 12'h340, 5'd2, 5'd0, 32'h1, 2'd3, 32'h5, 1, o);
        compared++; if (o.done_k !== 1 || o.illegal !== 1'b1 || o.wr_en !== 1'b0) begin errors++; $display("FAIL funct3_000 got done=%0d ill=%b wr=%b exp 1 1 0", o.done_k, o.illegal, o.wr_en); end
`ifdef CSR_PRIV_CHECK_EN
        run_instr(3'b001, 12'hF11, 5'd1, 5'd5, 32'h1, 2'd3, 32'h5, 1, o);
        compared++; if (o.done_k !== 1 || o.illegal !== 1'b1 || o.wr_en !== 1'b0 || o.rden_cnt !== 0) begin errors++; $display("FAIL ro_write got done=%0d ill=%b wr=%b exp 1 1 0", o.done_k, o.illegal, o.wr_en); end
        run_instr(3'b010, 12'h300, 5'd0, 5'd5, 32'h1, 2'd0, 32'h5, 1, o);
        compared++; if (o.done_k !== 1 || o.illegal !== 1'b1 || o.rd_we !== 1'b0 || o.rden_cnt !== 0) begin errors++; $display("FAIL priv_low got done=%0d ill=%b we=%b exp 1 1 0", o.done_k, o.illegal, o.rd_we); end
`else
        run_instr(3'b001, 12'hF11, 5'd1, 5'd0, 32'hA5, 2'd0, 32'h5, 1, o);
        compared++; if (o.done_k !== 1 || o.illegal !== 1'b0 || o.wr_en !== 1'b1 || o.wr_data !== 32'hA5) begin errors++; $display("FAIL ro_write_issued got done=%0d ill=%b wr=%b d=%h exp 1 0 1 a5", o.done_k, o.illegal, o.wr_en, o.wr_data); end
`endif
    endtask

    task automatic test_mid_reset();
        obs_t o;
        int   dones;
        @(negedge clk);
        bus.i_req_valid = 1'b1; bus.i_funct3 = 3'b010; bus.i_csr_addr = 12'h305;
        bus.i_rs1_addr_uimm = 5'd1; bus.i_rd_addr = 5'd3; bus.i_rs1_data = 32'hF0;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++; if (bus.o_req_ready !== 1'b1 || bus.o_csr_rd_en !== 1'b0 || bus.o_csr_wr_en !== 1'b0 ||
                        bus.o_rd_we !== 1'b0 || bus.o_done !== 1'b0 || bus.o_csr_addr !== 12'd0) begin
            errors++; $display("FAIL mid_reset_idle got rdy=%b rden=%b wr=%b we=%b done=%b addr=%h exp 1 0 0 0 0 000",
                               bus.o_req_ready, bus.o_csr_rd_en, bus.o_csr_wr_en, bus.o_rd_we, bus.o_done, bus.o_csr_addr); end
        dones = 0;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1 || bus.o_csr_wr_en === 1'b1 || bus.o_rd_we === 1'b1) dones++;
        end
        compared++; if (dones !== 0) begin errors++; $display("FAIL mid_reset_no_commit got %0d strobe cycles exp 0", dones); end
        run_instr(3'b110, 12'h306, 5'd2, 5'd4, 32'h0, 2'd3, 32'h0, TO + 5, o);
        compared++; if (o.done_k !== 2 + TO || o.illegal !== 1'b1) begin errors++; $display("FAIL post_reset_timeout got done=%0d ill=%b exp %0d 1", o.done_k, o.illegal, 2 + TO); end
    endtask

    task automatic test_random();
        obs_t        o;
        obs_t        e;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  uimm;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] old;
        logic [1:0]  priv;
        int          lat;
        int          p;
        for (int n = 0; n < 60; n++) begin
            f3   = 3'($urandom);
            addr = 12'($urandom);
            uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1  = $urandom;
            old  = $urandom;
            p    = $urandom_range(0, 2);
            priv = (p == 2) ? 2'd3 : 2'(p);
            lat  = $urandom_range(1, TO + 2);
            e = model(f3, addr, uimm, rd, rs1, priv, old, lat);
            run_instr(f3, addr, uimm, rd, rs1, priv, old, lat, o);
            compared++; if (o.done_k !== e.done_k || o.rden_k !== e.rden_k || o.rden_cnt !== e.rden_cnt) begin
                errors++; $display("FAIL rand_timing #%0d f3=%b got done=%0d rden=%0d/%0d exp %0d %0d/%0d", n, f3, o.done_k, o.rden_k, o.rden_cnt, e.done_k, e.rden_k, e.rden_cnt); end
            compared++; if ({o.illegal, o.wr_en, o.rd_we} !== {e.illegal, e.wr_en, e.rd_we}) begin
                errors++; $display("FAIL rand_flags #%0d f3=%b got ill/wr/we=%b%b%b exp %b%b%b", n, f3, o.illegal, o.wr_en, o.rd_we, e.illegal, e.wr_en, e.rd_we); end
            compared++; if ((e.wr_en && o.wr_data !== e.wr_data) || (e.rd_we && (o.rd_data !== e.rd_data || o.rd_addr !== e.rd_addr))) begin
                errors++; $display("FAIL rand_data #%0d f3=%b got wd=%h rd=%h ra=%0d exp %h %h %0d", n, f3, o.wr_data, o.rd_data, o.rd_addr, e.wr_data, e.rd_data, e.rd_addr); end
            compared++; if (o.ready0 !== 1'b1 || o.stray !== 0 || o.addr_bad !== 0) begin
                errors++; $display("FAIL rand_protocol #%0d got rdy=%b stray=%0d addr_bad=%0d exp 1 0 0", n, o.ready0, o.stray, o.addr_bad); end
        end
    endtask

    initial begin
        compared = 0;
        errors   = 0;
        rst      = 1'b1;
        test_reset();
        test_rw();
        test_set_clear();
        test_timeout();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
